// File: rtl/toeplitz_pkg.sv
// toeplitz_pkg: constants and types shared by the Toeplitz hashing datapath.
//   DefWidth     - default row / seed width in bits
//   DefNumRows   - default number of rows produced per run
//   DefRdLatency - default cycles from rd_en to a valid serial bit
//   shift_state_e - seed-row shifter FSM states (idle, request, wait, shift)
package toeplitz_pkg;

    localparam int unsigned DefWidth     = 3072;
    localparam int unsigned DefNumRows   = 3072;
    localparam int unsigned DefRdLatency = 2;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StShift
    } shift_state_e;

endpackage

// File: rtl/shift_seed_ctrl.sv
// shift_seed_ctrl: sequencing for the seed-row shifter.
// Detects the start edge, issues one read request per row, waits out the read
// latency, and tells the datapath when to load the seed and when to shift.
// Ports:
//   clk_i, rst_i     - clock, synchronous active-high reset
//   shift_en_i       - start request (rising-edge detected in idle)
//   load_o           - comb: load the seed into the row register this cycle
//   shift_o          - comb: shift the serial bit into the row this cycle
//   rd_en_o          - comb: request the next serial bit
//   sum_en_o         - registered: row register holds a new row
//   shift_ack_o      - registered: run complete
module shift_seed_ctrl
    import toeplitz_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = DefNumRows,
    parameter int unsigned RD_LATENCY = DefRdLatency
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic shift_en_i,
    output logic load_o,
    output logic shift_o,
    output logic rd_en_o,
    output logic sum_en_o,
    output logic shift_ack_o
);

    localparam int unsigned RowW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned LatW    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int unsigned LatLast = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam int unsigned RowLast = NUM_ROWS - 1;

    shift_state_e    state_q, state_d;
    logic [RowW-1:0] row_q, row_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic            en_prev_q;
    // Set once shift_en has been seen low since reset, so a level held high
    // through reset cannot masquerade as a rising edge.
    logic            armed_q;
    logic            sum_en_q, sum_en_d;
    logic            ack_q, ack_d;
    logic            start;

    assign start = shift_en_i & ~en_prev_q & armed_q;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        lat_d    = lat_q;
        load_o   = 1'b0;
        shift_o  = 1'b0;
        rd_en_o  = 1'b0;
        sum_en_d = 1'b0;
        ack_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load_o  = 1'b1;
                    row_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                rd_en_o = 1'b1;
                lat_d   = '0;
                state_d = (RD_LATENCY == 1) ? StShift : StWait;
            end
            StWait: begin
                // Counts RD_LATENCY-1 cycles: 0 .. RD_LATENCY-2.
                if (lat_q == LatW'(LatLast)) begin
                    state_d = StShift;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StShift: begin
                shift_o  = 1'b1;
                sum_en_d = 1'b1;
                if (row_q == RowW'(RowLast)) begin
                    ack_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            row_q     <= '0;
            lat_q     <= '0;
            en_prev_q <= 1'b0;
            armed_q   <= ~shift_en_i;
            sum_en_q  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            lat_q     <= lat_d;
            en_prev_q <= shift_en_i;
            armed_q   <= armed_q | ~shift_en_i;
            sum_en_q  <= sum_en_d;
            ack_q     <= ack_d;
        end
    end

    assign sum_en_o    = sum_en_q;
    assign shift_ack_o = ack_q;

endmodule

// File: rtl/shift_seed_row.sv
// shift_seed_row: holds one WIDTH-bit Toeplitz matrix row and advances it one
// bit per serial input bit, flagging each new row for the accumulator.
// Build option: define SHIFT_SEED_RIGHT_EN to shift right (bit enters at the
// MSB, bit 0 dropped); default shifts left (bit enters at bit 0, MSB dropped).
// Ports:
//   clk_in        - clock, rising edge
//   rst           - synchronous active-high reset
//   shift_en      - start request, rising-edge detected while idle
//   seed          - initial row, sampled only at start
//   shift_bit     - serial bit from the RAM reader
//   rd_en         - one-cycle request for the next serial bit
//   shift_ack     - one-cycle pulse, run complete
//   sum_en        - one-cycle pulse, shift_result holds a new row
//   shift_result  - current row register
module shift_seed_row
    import toeplitz_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned NUM_ROWS   = DefNumRows,
    parameter int unsigned RD_LATENCY = DefRdLatency
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] seed,
    input  logic             shift_bit,
    output logic             rd_en,
    output logic             shift_ack,
    output logic             sum_en,
    output logic [WIDTH-1:0] shift_result
);

    logic             load;
    logic             shift;
    logic [WIDTH-1:0] row_q, row_d;

    shift_seed_ctrl #(
        .NUM_ROWS   (NUM_ROWS),
        .RD_LATENCY (RD_LATENCY)
    ) u_ctrl (
        .clk_i       (clk_in),
        .rst_i       (rst),
        .shift_en_i  (shift_en),
        .load_o      (load),
        .shift_o     (shift),
        .rd_en_o     (rd_en),
        .sum_en_o    (sum_en),
        .shift_ack_o (shift_ack)
    );

    always_comb begin
        row_d = row_q;
        if (load) begin
            row_d = seed;
        end else if (shift) begin
`ifdef SHIFT_SEED_RIGHT_EN
            row_d = {shift_bit, row_q[WIDTH-1:1]};
`else
            row_d = {row_q[WIDTH-2:0], shift_bit};
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign shift_result = row_q;

endmodule

// File: tb/tb_shift_seed_row.sv
// tb_shift_seed_row: two instances (RD_LATENCY=2/NUM_ROWS=4 and
// RD_LATENCY=1/NUM_ROWS=2), driven with directed and random runs and compared
// cycle by cycle against a timing/row model derived from the row period.
module tb_shift_seed_row;

    localparam int unsigned W  = 8;
    localparam int unsigned N0 = 4;
    localparam int unsigned L0 = 2;
    localparam int unsigned N1 = 2;
    localparam int unsigned L1 = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en0 = 1'b0, en1 = 1'b0;
    logic [W-1:0] seed0 = '0, seed1 = '0;
    logic         bit0 = 1'b0, bit1 = 1'b0;
    logic         rd0, rd1, sum0, sum1, ack0, ack1;
    logic [W-1:0] res0, res1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_seed_row #(.WIDTH(W), .NUM_ROWS(N0), .RD_LATENCY(L0)) u_dut0 (
        .clk_in       (clk),
        .rst          (rst),
        .shift_en     (en0),
        .seed         (seed0),
        .shift_bit    (bit0),
        .rd_en        (rd0),
        .shift_ack    (ack0),
        .sum_en       (sum0),
        .shift_result (res0)
    );

    shift_seed_row #(.WIDTH(W), .NUM_ROWS(N1), .RD_LATENCY(L1)) u_dut1 (
        .clk_in       (clk),
        .rst          (rst),
        .shift_en     (en1),
        .seed         (seed1),
        .shift_bit    (bit1),
        .rd_en        (rd1),
        .shift_ack    (ack1),
        .sum_en       (sum1),
        .shift_result (res1)
    );

    // Row after n serial bits, as plain arithmetic on the seed value.
    function automatic logic [W-1:0] model_row(input logic [W-1:0] s, input logic [3:0] bits,
                                               input int n);
        int unsigned r = s;
        for (int i = 0; i < n; i++) begin
`ifdef SHIFT_SEED_RIGHT_EN
            r = (r >> 1) + (int'(bits[i]) << (W - 1));
`else
            r = ((r << 1) + int'(bits[i])) % (1 << W);
`endif
        end
        return W'(r);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic en, input logic [W-1:0] s, input logic b);
        if (sel == 0) begin
            en0 = en; seed0 = s; bit0 = b;
        end else begin
            en1 = en; seed1 = s; bit1 = b;
        end
    endtask

    // One run on instance sel; shift_en must have been low at the last edge.
    // toggle: wiggle shift_en randomly mid-run. hold: extra idle cycles with
    // shift_en still high, which must not retrigger.
    task automatic run(input int sel, input logic [W-1:0] s, input logic [3:0] bits,
                       input bit toggle, input int hold);
        int n   = (sel == 0) ? int'(N0) : int'(N1);
        int l   = (sel == 0) ? int'(L0) : int'(L1);
        int per = l + 1;
        int t   = n * per + 1;
        logic         rd, sm, ak, en_v, b_v;
        logic [W-1:0] res;
        @(negedge clk);
        drive(sel, 1'b1, s, 1'b0);
        for (int c = 1; c <= t + 2 + hold; c++) begin
            int k  = (c - 1) / per;
            int ph = (c - 1) % per;
            @(negedge clk);
            rd  = (sel == 0) ? rd0  : rd1;
            sm  = (sel == 0) ? sum0 : sum1;
            ak  = (sel == 0) ? ack0 : ack1;
            res = (sel == 0) ? res0 : res1;
            check("rd_en", W'(rd), W'(ph == 0 && k < n));
            check("sum_en", W'(sm), W'(ph == 0 && k >= 1 && k <= n));
            check("shift_ack", W'(ak), W'(c == t));
            check("shift_result", res, model_row(s, bits, (k < n) ? k : n));
            en_v = (toggle && c < t - 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            b_v  = (ph == l && k < n) ? bits[k] : 1'($urandom_range(0, 1));
            drive(sel, en_v, W'($urandom), b_v);
        end
        @(negedge clk);
        drive(sel, 1'b0, W'($urandom), 1'b0);
    endtask

    initial begin
        logic [W-1:0] rs;
        logic [3:0]   rb;

        // Reset with shift_en held high: outputs zero, no run afterwards.
        rst = 1'b1;
        en0 = 1'b1;
        en1 = 1'b1;
        seed0 = W'($urandom);
        seed1 = W'($urandom);
        repeat (3) @(negedge clk);
        check("reset rd_en", W'(rd0), '0);
        check("reset sum_en", W'(sum0), '0);
        check("reset shift_ack", W'(ack0), '0);
        check("reset shift_result", res0, '0);
        check("reset shift_result 1", res1, '0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held-through-reset rd_en", W'(rd0), '0);
            check("held-through-reset rd_en 1", W'(rd1), '0);
            check("held-through-reset result", res0, '0);
        end
        en0 = 1'b0;
        en1 = 1'b0;
        @(negedge clk);

        // Reference stream: seed 0x05, bits 1,0,1,1.
        run(0, 8'h05, 4'b1101, 1'b0, 0);
`ifdef SHIFT_SEED_RIGHT_EN
        check("stream final row", res0, 8'hD0);
`else
        check("stream final row", res0, 8'h5B);
`endif

        // MSB / LSB drop corners.
        run(0, 8'h80, 4'b0000, 1'b0, 0);
        run(0, 8'h01, 4'b1111, 1'b0, 0);
        run(1, 8'h80, 4'b0000, 1'b0, 0);
        run(1, 8'h05, 4'b0011, 1'b0, 0);

        // Level hold: shift_en high for 100 cycles gives exactly one run.
        run(0, 8'hA5, 4'b1010, 1'b0, 100 - int'(N0 * (L0 + 1)) - 3);
        run(0, 8'h3C, 4'b0110, 1'b0, 0);

        // Reset during row 2 (cycle of its rd_en), shift_en still high.
        @(negedge clk);
        drive(0, 1'b1, 8'h05, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            bit0  = 1'($urandom_range(0, 1));
            seed0 = W'($urandom);
        end
        check("row 2 rd_en before reset", W'(rd0), 8'h01);
        rst = 1'b1;
        @(negedge clk);
        check("mid-run reset rd_en", W'(rd0), '0);
        check("mid-run reset sum_en", W'(sum0), '0);
        check("mid-run reset shift_ack", W'(ack0), '0);
        check("mid-run reset shift_result", res0, '0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post-reset idle rd_en", W'(rd0), '0);
        end
        en0 = 1'b0;
        @(negedge clk);
        run(0, 8'h05, 4'b1101, 1'b0, 0);

        // Random runs, with shift_en and seed disturbed mid-run.
        for (int i = 0; i < 12; i++) begin
            rs = W'($urandom);
            rb = 4'($urandom);
            run(i % 2, rs, rb, (i % 3) != 0, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
